// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the external memory port arbiter: state encoding and address width.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 25;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Counts idle data-phase cycles between word acks; fires when the idle run reaches TIMEOUT.
module mem_port_arbiter_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic ack,
  output logic fire
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] idle_cnt;

  // Fires on the TIMEOUT-th consecutive cycle without an ack.
  assign fire = en && !ack && (idle_cnt == W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (!en || ack || fire) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between the ADC write stream and the brush read stream,
// one burst at a time, with per-word address-advance pulses back to the address generator.
//   state  | meaning
//   S_IDLE | evaluate requests, latch grant direction and start address
//   S_CMD  | hold burst command until the controller accepts it
//   S_DATA | count word acks, pulse *_addr_up, watchdog armed
//   S_GAP  | one settle cycle for the address generator
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
  parameter int BURST_LEN  = 16,
  parameter int LVL_W      = 10,
  parameter int URGENT_LVL = 768,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [LVL_W-1:0]  wr_fifo_level,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              wr_addr_up,
  output logic              rd_addr_up,
  output logic              wr_fifo_rd,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  input  logic              mem_wack,
  input  logic              mem_rvalid,
  output logic              busy,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  arb_state_e       state;
  logic             last_we;
  logic [CNT_W-1:0] word_cnt;
  logic             in_data;
  logic             wr_ack;
  logic             rd_ack;
  logic             word_ack;
  logic             wd_fire;
  logic             urgent;
  logic             grant_we;

  assign in_data  = (state == S_DATA);
  assign wr_ack   = in_data && mem_cmd_we && mem_wack;
  assign rd_ack   = in_data && !mem_cmd_we && mem_rvalid;
  assign word_ack = wr_ack || rd_ack;

  assign wr_addr_up = wr_ack;
  assign wr_fifo_rd = wr_ack;
  assign rd_addr_up = rd_ack;

  // A nearly full write FIFO overrides round-robin so ADC samples are never dropped.
  assign urgent   = wr_req && (wr_fifo_level >= LVL_W'(URGENT_LVL));
  assign grant_we = urgent || (wr_req && (!rd_req || !last_we));

  mem_port_arbiter_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk  (clk),
    .reset(reset),
    .en   (in_data),
    .ack  (word_ack),
    .fire (wd_fire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      last_we       <= 1'b1;
      word_cnt      <= '0;
      mem_cmd_valid <= 1'b0;
      mem_cmd_we    <= 1'b0;
      mem_cmd_addr  <= '0;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (wr_req || rd_req) begin
            state         <= S_CMD;
            mem_cmd_we    <= grant_we;
            last_we       <= grant_we;
            mem_cmd_addr  <= grant_we ? wr_addr : rd_addr;
            mem_cmd_valid <= 1'b1;
            busy          <= 1'b1;
          end
        end
        S_CMD: begin
          if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            word_cnt      <= '0;
            state         <= S_DATA;
          end
        end
        S_DATA: begin
          if (word_ack) begin
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == CNT_W'(BURST_LEN - 1)) begin
              state <= S_GAP;
            end
          end else if (wd_fire) begin
            err_timeout <= 1'b1;
            state       <= S_GAP;
          end
        end
        S_GAP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized directed bench for mem_port_arbiter with a transaction-level grant model.
module tb_mem_port_arbiter;

  localparam int BURST_LEN  = 16;
  localparam int LVL_W      = 10;
  localparam int URGENT_LVL = 768;
  localparam int TIMEOUT    = 255;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             wr_req = 1'b0;
  logic [LVL_W-1:0] wr_fifo_level = '0;
  logic             rd_req = 1'b0;
  logic [24:0]      wr_addr = '0;
  logic [24:0]      rd_addr = '0;
  logic             wr_addr_up;
  logic             rd_addr_up;
  logic             wr_fifo_rd;
  logic             mem_cmd_valid;
  logic             mem_cmd_ready = 1'b0;
  logic             mem_cmd_we;
  logic [24:0]      mem_cmd_addr;
  logic             mem_wack = 1'b0;
  logic             mem_rvalid = 1'b0;
  logic             busy;
  logic             err_timeout;

  int n_pass  = 0;
  int n_total = 0;
  bit last_we_m = 1'b1;

  mem_port_arbiter #(
    .BURST_LEN (BURST_LEN),
    .LVL_W     (LVL_W),
    .URGENT_LVL(URGENT_LVL),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_req       (wr_req),
    .wr_fifo_level(wr_fifo_level),
    .rd_req       (rd_req),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .wr_addr_up   (wr_addr_up),
    .rd_addr_up   (rd_addr_up),
    .wr_fifo_rd   (wr_fifo_rd),
    .mem_cmd_valid(mem_cmd_valid),
    .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we   (mem_cmd_we),
    .mem_cmd_addr (mem_cmd_addr),
    .mem_wack     (mem_wack),
    .mem_rvalid   (mem_rvalid),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Grant rule: urgent write first, else alternate when contested, else whoever asks.
  function automatic bit model_we(input bit wr, input bit rd, input int lvl, input bit last);
    if (wr && lvl >= URGENT_LVL) return 1'b1;
    if (wr && rd) return !last;
    return wr;
  endfunction

  task automatic wait_cmd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (mem_cmd_valid === 1'b1) ok = 1'b1;
    end
    check("cmd_seen", 32'(ok), 32'd1);
  endtask

  // Runs one burst from command to the following IDLE cycle; returns at that IDLE negedge.
  task automatic do_burst(input bit exp_we, input logic [24:0] exp_addr, input int delay,
                          input bit dense);
    bit ok;
    bit give;
    bit stray;
    int busy_cycles;
    int data_cycles;
    int acks;
    int obs_pulses;
    int bad;
    busy_cycles = 0; data_cycles = 0; acks = 0; obs_pulses = 0; bad = 0;
    wait_cmd(ok);
    if (!ok) return;
    check("cmd_we", 32'(mem_cmd_we), 32'(exp_we));
    check("cmd_addr", 32'(mem_cmd_addr), 32'(exp_addr));
    for (int i = 0; i < delay; i++) begin
      busy_cycles += int'(busy);
      if (mem_cmd_valid !== 1'b1 || mem_cmd_we !== exp_we || mem_cmd_addr !== exp_addr ||
          wr_addr_up !== 1'b0 || rd_addr_up !== 1'b0) bad++;
      mem_wack   = 1'($urandom_range(0, 1));
      mem_rvalid = 1'($urandom_range(0, 1));
      wr_addr    = 25'($urandom);
      rd_addr    = 25'($urandom);
      @(negedge clk);
    end
    if (mem_cmd_valid !== 1'b1 || mem_cmd_we !== exp_we || mem_cmd_addr !== exp_addr ||
        wr_addr_up !== 1'b0 || rd_addr_up !== 1'b0) bad++;
    check("cmd_stall_stable", 32'(bad), 32'd0);
    busy_cycles += int'(busy);
    mem_wack = 1'b0;
    mem_rvalid = 1'b0;
    mem_cmd_ready = 1'b1;
    @(negedge clk);
    mem_cmd_ready = 1'b0;
    wr_addr = 25'($urandom);
    rd_addr = 25'($urandom);
    bad = 0;
    while (acks < BURST_LEN && data_cycles < 200) begin
      data_cycles++;
      busy_cycles += int'(busy);
      give  = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
      stray = 1'($urandom_range(0, 1));
      if (exp_we) begin mem_wack = give; mem_rvalid = stray; end
      else begin mem_rvalid = give; mem_wack = stray; end
      #1;
      if (wr_addr_up !== (exp_we && give) || rd_addr_up !== (!exp_we && give) ||
          wr_fifo_rd !== (exp_we && give) || mem_cmd_valid !== 1'b0) bad++;
      obs_pulses += exp_we ? int'(wr_addr_up) : int'(rd_addr_up);
      acks += int'(give);
      @(negedge clk);
    end
    check("data_pulse_gating", 32'(bad), 32'd0);
    check("burst_pulses", 32'(obs_pulses), 32'(BURST_LEN));
    mem_wack = 1'b1;
    mem_rvalid = 1'b1;
    #1;
    busy_cycles += int'(busy);
    check("gap_busy", 32'(busy), 32'd1);
    check("gap_no_pulse", 32'({wr_addr_up, rd_addr_up, wr_fifo_rd}), 32'd0);
    @(negedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_no_pulse", 32'({wr_addr_up, rd_addr_up, wr_fifo_rd}), 32'd0);
    mem_wack = 1'b0;
    mem_rvalid = 1'b0;
    check("busy_cycles", 32'(busy_cycles), 32'(delay + 1 + data_cycles + 1));
  endtask

  task automatic next_burst(input int delay, input bit dense);
    bit we;
    logic [24:0] a;
    we = model_we(wr_req, rd_req, int'(wr_fifo_level), last_we_m);
    last_we_m = we;
    a = we ? wr_addr : rd_addr;
    do_burst(we, a, delay, dense);
  endtask

  initial begin
    bit ok;
    int obs_rd;
    int silent_pulses;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(mem_cmd_valid), 32'd0);
    check("rst_we", 32'(mem_cmd_we), 32'd0);
    check("rst_addr", 32'(mem_cmd_addr), 32'd0);
    check("rst_pulses", 32'({wr_addr_up, rd_addr_up, wr_fifo_rd}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Write only, instant ready, one wack per cycle
    wr_fifo_level = 10'd100;
    wr_addr = 25'($urandom);
    wr_req = 1'b1;
    next_burst(0, 1'b1);
    wr_req = 1'b0;
    repeat (2) @(negedge clk);

    // Contested, below urgent level: alternate starting with read
    wr_fifo_level = 10'($urandom_range(0, URGENT_LVL - 1));
    wr_req = 1'b1;
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_burst($urandom_range(0, 3), 1'b0);
      check("alt_we", 32'(last_we_m), 32'(i % 2));
    end
    // Contested, urgent level: writes only
    wr_fifo_level = 10'($urandom_range(URGENT_LVL, 1023));
    for (int i = 0; i < 4; i++) next_burst($urandom_range(0, 2), 1'b0);
    wr_fifo_level = 10'($urandom_range(0, URGENT_LVL - 1));
    next_burst(0, 1'b0);
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (2) @(negedge clk);

    // Controller not ready for 10 cycles
    wr_req = 1'b1;
    next_burst(10, 1'b0);
    wr_req = 1'b0;
    @(negedge clk);

    // Read burst aborted by watchdog after 5 words
    rd_req = 1'b1;
    last_we_m = model_we(1'b0, 1'b1, 0, last_we_m);
    wait_cmd(ok);
    check("to_cmd_we", 32'(mem_cmd_we), 32'd0);
    check("to_cmd_addr", 32'(mem_cmd_addr), 32'(rd_addr));
    mem_cmd_ready = 1'b1;
    @(negedge clk);
    mem_cmd_ready = 1'b0;
    obs_rd = 0;
    for (int i = 0; i < 5; i++) begin
      mem_rvalid = 1'b1;
      #1;
      obs_rd += int'(rd_addr_up);
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    rd_req = 1'b0;
    silent_pulses = 0;
    for (int j = 1; j <= 256; j++) begin
      mem_wack = 1'($urandom_range(0, 1));
      #1;
      silent_pulses += int'(rd_addr_up) + int'(wr_addr_up);
      @(negedge clk);
      if (j == 254) begin
        check("to_err_before", 32'(err_timeout), 32'd0);
        check("to_busy_before", 32'(busy), 32'd1);
      end
      if (j == 255) begin
        check("to_err_set", 32'(err_timeout), 32'd1);
        check("to_busy_gap", 32'(busy), 32'd1);
      end
    end
    mem_wack = 1'b0;
    check("to_rd_pulses", 32'(obs_rd), 32'd5);
    check("to_silent_pulses", 32'(silent_pulses), 32'd0);
    check("to_idle", 32'(busy), 32'd0);
    wr_req = 1'b1;
    wr_fifo_level = 10'd100;
    next_burst(1, 1'b0);
    check("to_err_sticky", 32'(err_timeout), 32'd1);

    // Reset during DATA after 7 wacks
    wait_cmd(ok);
    last_we_m = 1'b1;
    mem_cmd_ready = 1'b1;
    @(negedge clk);
    mem_cmd_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mem_wack = 1'b1;
      @(negedge clk);
    end
    mem_wack = 1'b1;
    reset = 1'b0;
    #1;
    check("mid_rst_outputs",
          32'({mem_cmd_valid, mem_cmd_we, wr_addr_up, rd_addr_up, wr_fifo_rd, busy, err_timeout}),
          32'd0);
    check("mid_rst_addr", 32'(mem_cmd_addr), 32'd0);
    @(negedge clk);
    check("in_rst_no_pulse", 32'({wr_addr_up, wr_fifo_rd, busy}), 32'd0);
    mem_wack = 1'b0;
    wr_req = 1'b0;
    reset = 1'b1;
    #1;
    check("post_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    wr_req = 1'b1;
    rd_req = 1'b1;
    rd_addr = 25'($urandom);
    next_burst(0, 1'b0);
    check("post_rst_first_read", 32'(last_we_m), 32'd0);
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
